ghost_mode_scheduler: RTL and testbench
=======================================

Name: ghost_mode_scheduler

Overview:
- Generates the global ghost behaviour mode (IDLE/CHASE/SCATTER/FRIGHTENED/DIED/PAUSE) that drives the ghost speed table and ghost AI.
- Owns the per-level scatter/chase phase timetable, the frightened override timer and the pause/death sequencing.
- Turns the speed table's period output into a single-cycle movement strobe.
- Sits between game-flow control (start, pellet, death, level clear) and the ghost movers.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per game second (set to 10 in simulation).
- WARN_SECS, 2, number of final frightened seconds during which o_fright_warn is high.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; begins play from IDLE or DIED.
- i_pause  in  1  pulse; toggles pause.
- i_power_pellet  in  1  pulse; power pellet eaten.
- i_pacman_died  in  1  pulse; Pac-Man caught.
- i_level_clear  in  1  pulse; all dots eaten.
- i_level  in  8  current level, 1-based.
- i_speed  in  28  step period in cycles, from the speed table.
- o_mode  out  4  IDLE=0, CHASE=1, SCATTER=2, FRIGHTENED=3, DIED=4, PAUSE=5.
- o_phase  out  3  scatter/chase phase index, 0..7.
- o_mode_changed  out  1  one-cycle pulse on every CHASE<->SCATTER transition and on FRIGHTENED entry; ghosts reverse on this pulse.
- o_fright_warn  out  1  high in the last WARN_SECS seconds of FRIGHTENED.
- o_step_tick  out  1  one-cycle movement strobe.

Behaviour:
- Reset values: o_mode=IDLE, o_phase=0, all other outputs 0; all counters cleared.
- All outputs are registered. A response appears one cycle after the input event.
- Phase table, in seconds, mode alternating S,C,S,C,S,C,S,C:
  - level<=1: 7,20,7,20,5,20,5,forever.
  - level>=2: 5,20,5,20,5,20,1,forever.
  - Even phases are SCATTER; odd phases are CHASE. Phase 7 has no timer and holds CHASE.
- Second prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in CHASE, SCATTER or FRIGHTENED.
  - Emits an internal sec_tick on wrap.
  - Cleared on every timer load.
- Phase timer:
  - Loaded with the table value on phase entry.
  - Decrements on sec_tick in CHASE/SCATTER.
  - Reaching 0 advances the phase and toggles the mode.
  - Phase length is therefore exactly D*TICKS_PER_SEC cycles.
  - Frozen during FRIGHTENED and PAUSE, keeping its remaining whole seconds; the prescaler restarts on resume.
- FRIGHTENED:
  - Entered from CHASE/SCATTER on i_power_pellet; the current mode is saved.
  - Fright timer is 6 s at level<=1, 5 s at level 2, 3 s at level>=3.
  - i_power_pellet during FRIGHTENED reloads the timer without pulsing o_mode_changed.
  - On expiry, return to the saved mode.
  - i_power_pellet is ignored in IDLE, DIED and PAUSE.
- o_fright_warn: high while in FRIGHTENED and remaining seconds <= WARN_SECS.
- PAUSE:
  - i_pause in CHASE/SCATTER/FRIGHTENED saves the mode and enters PAUSE.
  - i_pause in PAUSE restores the saved mode.
  - All timers and the step counter are frozen while paused.
  - i_pause is ignored in IDLE and DIED.
- DIED: i_pacman_died from any mode except IDLE enters DIED. The fright state is discarded.
- Start:
  - i_start in IDLE or DIED enters SCATTER at phase 0 with the timer loaded.
  - i_start is ignored in other modes.
- Level clear: i_level_clear enters IDLE from any mode and clears phase, timers and saved state.
- Simultaneous inputs resolve by priority: i_rst > i_level_clear > i_pacman_died > i_pause > i_power_pellet > timer expiry > i_start.
- Step generator:
  - Counter runs in CHASE, SCATTER, FRIGHTENED and DIED.
  - o_step_tick pulses when the count reaches the latched period minus 1; the counter then returns to 0.
  - The period is latched from i_speed at each tick and on mode change; i_speed=0 is treated as 1 (tick every cycle).
  - The counter is held in PAUSE and cleared in IDLE.

Test Plan:
- TICKS_PER_SEC=10, level 1:
  - i_start -> o_mode=2, o_phase=0 next cycle; o_mode=1, o_phase=1 exactly 70 cycles later, with an o_mode_changed pulse.
  - Run through all phases -> durations 70,200,70,200,50,200,50 cycles; then o_mode holds 1 with o_phase=7 for 1000+ cycles.
- Level 1, i_power_pellet 30 cycles into phase 1:
  - o_mode=3 with o_mode_changed.
  - o_fright_warn rises 40 cycles later.
  - o_mode returns to 1 after 60 cycles; phase 1 ends 170 cycles after that.
  - At level 3 the fright lasts 30 cycles.
- Pellet re-eaten 50 cycles into fright -> fright ends 60 cycles after the second pellet; only one o_mode_changed pulse.
- i_pause in SCATTER for 500 cycles -> o_mode=5, no o_step_tick; second i_pause restores mode 2 and the remaining phase time.
- i_speed=4 in CHASE -> o_step_tick every 4 cycles; i_speed=0 -> tick every cycle.
- i_pacman_died and i_power_pellet in the same cycle -> o_mode=4; a later i_start gives o_mode=2, o_phase=0. i_level_clear plus i_pause in the same cycle -> o_mode=0.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode generator: scatter/chase timetable, fright override,
// pause/death sequencing and the movement strobe.
module ghost_mode_scheduler #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int WARN_SECS     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_power_pellet,
  input  logic        i_pacman_died,
  input  logic        i_level_clear,
  input  logic [7:0]  i_level,
  input  logic [27:0] i_speed,
  output logic [3:0]  o_mode,
  output logic [2:0]  o_phase,
  output logic        o_mode_changed,
  output logic        o_fright_warn,
  output logic        o_step_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [4:0] WARN = 5'(WARN_SECS);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CHASE   = 4'd1,
    SCATTER = 4'd2,
    FRIGHT  = 4'd3,
    DIED    = 4'd4,
    PAUSE   = 4'd5
  } mode_e;

  mode_e         mode_q, mode_d;
  mode_e         fret_q, fret_d;
  mode_e         pret_q, pret_d;
  logic [2:0]    phase_q, phase_d;
  logic [4:0]    pt_q, pt_d;
  logic [4:0]    ft_q, ft_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [27:0]   cnt_q, cnt_d;
  logic [27:0]   per_q, per_d;
  logic          chg_q, chg_d;
  logic          warn_q, warn_d;
  logic          tick_q, tick_d;

  logic        cs, fr, counting, running, sec_tick, ph_exp, fr_exp;
  logic [27:0] eff;

  function automatic logic [4:0] phase_secs(
    input logic [7:0] lvl,
    input logic [2:0] ph
  );
    logic [4:0] r;
    logic       lo;
    lo = (lvl <= 8'd1);
    case (ph)
      3'd0, 3'd2:       r = lo ? 5'd7 : 5'd5;
      3'd1, 3'd3, 3'd5: r = 5'd20;
      3'd4:             r = 5'd5;
      3'd6:             r = lo ? 5'd5 : 5'd1;
      default:          r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] fright_secs(input logic [7:0] lvl);
    logic [4:0] r;
    if (lvl <= 8'd1)      r = 5'd6;
    else if (lvl == 8'd2) r = 5'd5;
    else                  r = 5'd3;
    return r;
  endfunction

  assign cs       = (mode_q == CHASE) || (mode_q == SCATTER);
  assign fr       = (mode_q == FRIGHT);
  assign counting = cs || fr;
  assign running  = counting || (mode_q == DIED);
  assign sec_tick = counting && (presc_q == PMAX);
  // phase 7 is loaded with 0 and never expires
  assign ph_exp   = cs && sec_tick && (phase_q != 3'd7) && (pt_q == 5'd1);
  assign fr_exp   = fr && sec_tick && (ft_q == 5'd1);
  assign eff      = (i_speed == 28'd0) ? 28'd1 : i_speed;

  always_comb begin
    mode_d  = mode_q;
    fret_d  = fret_q;
    pret_d  = pret_q;
    phase_d = phase_q;
    pt_d    = pt_q;
    ft_d    = ft_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    chg_d   = 1'b0;
    tick_d  = 1'b0;
    warn_d  = 1'b0;

    if (counting) presc_d = sec_tick ? '0 : presc_q + PW'(1);
    if (cs && sec_tick && pt_q > 5'd1) pt_d = pt_q - 5'd1;
    if (fr && sec_tick && ft_q > 5'd1) ft_d = ft_q - 5'd1;

    if (i_level_clear) begin
      mode_d  = IDLE;
      fret_d  = IDLE;
      pret_d  = IDLE;
      phase_d = 3'd0;
      pt_d    = 5'd0;
      ft_d    = 5'd0;
      presc_d = '0;
    end else if (i_pacman_died && mode_q != IDLE) begin
      mode_d  = DIED;
      fret_d  = IDLE;
      pret_d  = IDLE;
      ft_d    = 5'd0;
      presc_d = '0;
    end else if (i_pause && counting) begin
      pret_d  = mode_q;
      mode_d  = PAUSE;
      presc_d = '0;
    end else if (i_pause && mode_q == PAUSE) begin
      mode_d = pret_q;
    end else if (i_power_pellet && counting) begin
      mode_d  = FRIGHT;
      ft_d    = fright_secs(i_level);
      presc_d = '0;
      if (!fr) begin
        fret_d = mode_q;
        chg_d  = 1'b1;
      end
    end else if (ph_exp) begin
      phase_d = phase_q + 3'd1;
      mode_d  = (mode_q == SCATTER) ? CHASE : SCATTER;
      pt_d    = phase_secs(i_level, phase_q + 3'd1);
      presc_d = '0;
      chg_d   = 1'b1;
    end else if (fr_exp) begin
      mode_d  = fret_q;
      ft_d    = 5'd0;
      presc_d = '0;
    end else if (i_start && (mode_q == IDLE || mode_q == DIED)) begin
      mode_d  = SCATTER;
      phase_d = 3'd0;
      pt_d    = phase_secs(i_level, 3'd0);
      ft_d    = 5'd0;
      presc_d = '0;
    end

    warn_d = (mode_d == FRIGHT) && (ft_d <= WARN);

    // >= keeps the strobe sane if a shorter period lands mid-count
    if (mode_q == IDLE) begin
      cnt_d = 28'd0;
    end else if (running) begin
      if (cnt_q >= per_q - 28'd1) begin
        cnt_d  = 28'd0;
        tick_d = 1'b1;
        per_d  = eff;
      end else begin
        cnt_d = cnt_q + 28'd1;
      end
    end
    if (mode_d != mode_q) per_d = eff;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q  <= IDLE;
      fret_q  <= IDLE;
      pret_q  <= IDLE;
      phase_q <= 3'd0;
      pt_q    <= 5'd0;
      ft_q    <= 5'd0;
      presc_q <= '0;
      cnt_q   <= 28'd0;
      per_q   <= 28'd1;
      chg_q   <= 1'b0;
      warn_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      fret_q  <= fret_d;
      pret_q  <= pret_d;
      phase_q <= phase_d;
      pt_q    <= pt_d;
      ft_q    <= ft_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      chg_q   <= chg_d;
      warn_q  <= warn_d;
      tick_q  <= tick_d;
    end
  end

  assign o_mode         = mode_q;
  assign o_phase        = phase_q;
  assign o_mode_changed = chg_q;
  assign o_fright_warn  = warn_q;
  assign o_step_tick    = tick_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: vector table, timed sequences and a
// randomized run against a second-counting reference model.
module tb_ghost_mode_scheduler;

  localparam int T = 10;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst, start, pause, pellet, died, clear;
  logic [7:0]  level;
  logic [27:0] speed;
  logic [3:0]  o_mode;
  logic [2:0]  o_phase;
  logic        o_chg, o_warn, o_tick;

  int checks = 0;
  int errors = 0;

  ghost_mode_scheduler #(.TICKS_PER_SEC(T), .WARN_SECS(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause),
    .i_power_pellet(pellet), .i_pacman_died(died),
    .i_level_clear(clear), .i_level(level), .i_speed(speed),
    .o_mode(o_mode), .o_phase(o_phase), .o_mode_changed(o_chg),
    .o_fright_warn(o_warn), .o_step_tick(o_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s, p, pp, d, c;
    int mode;
    bit chg;
  } vec_t;
  vec_t vt[20];

  int tbl_lo[7] = '{7, 20, 7, 20, 5, 20, 5};
  int tbl_hi[7] = '{5, 20, 5, 20, 5, 20, 1};
  int durs[7]   = '{70, 200, 70, 200, 50, 200, 50};

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; pause = 0; pellet = 0; died = 0; clear = 0;
  endtask

  task automatic wait_change(input int lim, output int n);
    int prev;
    prev = o_mode;
    n = 0;
    do begin
      cyc();
      n++;
    end while (o_mode == prev && n < lim);
  endtask

  task automatic do_clear_start(input int lvl);
    level = 8'(lvl);
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
  endtask

  // Reference model: whole seconds remaining per timer plus the cycle
  // position inside the current second; -1 seconds means "no end".
  int m_mode, m_phase, m_psec, m_fsec, m_sub, m_fret, m_pret;
  int m_cnt, m_per;
  bit e_chg, e_warn, e_tick;

  function automatic int phase_len(input int lvl, input int ph);
    if (ph >= 7) return -1;
    return (lvl <= 1) ? tbl_lo[ph] : tbl_hi[ph];
  endfunction

  function automatic int fright_len(input int lvl);
    if (lvl <= 1) return 6;
    if (lvl == 2) return 5;
    return 3;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_psec = 0; m_fsec = 0; m_sub = 0;
    m_fret = 0; m_pret = 0; m_cnt = 0; m_per = 1;
    e_chg = 0; e_warn = 0; e_tick = 0;
  endtask

  task automatic model_step();
    int old, eff, lvl;
    bit act, sec, ph_done, fr_done;
    old = m_mode;
    lvl = int'(level);
    eff = (speed == 0) ? 1 : int'(speed);
    act = (m_mode >= 1 && m_mode <= 3);
    sec = act && (m_sub == T - 1);
    ph_done = 0; fr_done = 0;
    e_chg = 0; e_tick = 0;
    if (act) m_sub = sec ? 0 : m_sub + 1;
    if (sec && (m_mode == 1 || m_mode == 2) && m_psec > 0) begin
      if (m_psec == 1) ph_done = 1;
      else m_psec--;
    end
    if (sec && m_mode == 3) begin
      if (m_fsec == 1) fr_done = 1;
      else if (m_fsec > 1) m_fsec--;
    end
    if (clear) begin
      m_mode = 0; m_phase = 0; m_psec = 0; m_fsec = 0; m_sub = 0;
      m_fret = 0; m_pret = 0;
    end else if (died && m_mode != 0) begin
      m_mode = 4; m_fsec = 0; m_fret = 0; m_pret = 0; m_sub = 0;
    end else if (pause && act) begin
      m_pret = m_mode; m_mode = 5; m_sub = 0;
    end else if (pause && m_mode == 5) begin
      m_mode = m_pret;
    end else if (pellet && act) begin
      if (m_mode != 3) begin
        m_fret = m_mode;
        e_chg = 1;
      end
      m_mode = 3; m_fsec = fright_len(lvl); m_sub = 0;
    end else if (ph_done) begin
      m_phase++;
      m_mode = (m_mode == 2) ? 1 : 2;
      m_psec = phase_len(lvl, m_phase);
      m_sub = 0; e_chg = 1;
    end else if (fr_done) begin
      m_mode = m_fret; m_fsec = 0; m_sub = 0;
    end else if (start && (m_mode == 0 || m_mode == 4)) begin
      m_mode = 2; m_phase = 0; m_psec = phase_len(lvl, 0);
      m_fsec = 0; m_sub = 0;
    end
    e_warn = (m_mode == 3) && (m_fsec <= W);
    if (old == 0) begin
      m_cnt = 0;
    end else if (old != 5) begin
      if (m_cnt + 1 >= m_per) begin
        m_cnt = 0; e_tick = 1; m_per = eff;
      end else begin
        m_cnt++;
      end
    end
    if (m_mode != old) m_per = eff;
  endtask

  initial begin
    int n, bad, tk, last, gaps;
    vt[0]  = '{0,0,0,0,0, 0,0};
    vt[1]  = '{0,1,0,0,0, 0,0};
    vt[2]  = '{0,0,1,0,0, 0,0};
    vt[3]  = '{1,0,0,0,0, 2,0};
    vt[4]  = '{1,0,0,0,0, 2,0};
    vt[5]  = '{0,0,1,0,0, 3,1};
    vt[6]  = '{0,0,1,0,0, 3,0};
    vt[7]  = '{0,1,0,0,0, 5,0};
    vt[8]  = '{0,0,1,0,0, 5,0};
    vt[9]  = '{0,1,0,0,0, 3,0};
    vt[10] = '{0,0,1,1,0, 4,0};
    vt[11] = '{0,1,0,0,0, 4,0};
    vt[12] = '{1,0,0,0,0, 2,0};
    vt[13] = '{0,1,0,0,1, 0,0};
    vt[14] = '{0,0,0,1,0, 0,0};
    vt[15] = '{1,0,0,0,0, 2,0};
    vt[16] = '{1,1,0,0,0, 5,0};
    vt[17] = '{0,1,1,0,0, 2,0};
    vt[18] = '{1,0,1,0,0, 3,1};
    vt[19] = '{0,0,0,1,0, 4,0};

    rst = 1; idle_inputs(); level = 1; speed = 1;
    repeat (3) cyc();
    chk("rst_mode", o_mode, 0);
    chk("rst_phase", o_phase, 0);
    chk("rst_chg", o_chg, 0);
    chk("rst_warn", o_warn, 0);
    chk("rst_tick", o_tick, 0);
    rst = 0;

    for (int i = 0; i < 20; i++) begin
      start = vt[i].s; pause = vt[i].p; pellet = vt[i].pp;
      died = vt[i].d; clear = vt[i].c;
      cyc();
      idle_inputs();
      chk($sformatf("vec%0d_mode", i), o_mode, vt[i].mode);
      chk($sformatf("vec%0d_chg", i), o_chg, vt[i].chg);
    end

    // full timetable at level 1
    do_clear_start(1);
    chk("start_mode", o_mode, 2);
    chk("start_phase", o_phase, 0);
    for (int p = 0; p < 7; p++) begin
      wait_change(400, n);
      chk($sformatf("dur_phase%0d", p), n, durs[p]);
      chk($sformatf("chg_phase%0d", p), o_chg, 1);
      chk($sformatf("phase_idx%0d", p), o_phase, p + 1);
    end
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      if (o_mode != 1 || o_phase != 7) bad++;
    end
    chk("phase7_hold", bad, 0);

    // fright 30 cycles into phase 1
    do_clear_start(1);
    wait_change(200, n);
    chk("fr_p1_entry", n, 70);
    repeat (29) cyc();
    pellet = 1; cyc(); pellet = 0;
    chk("fr_mode", o_mode, 3);
    chk("fr_chg", o_chg, 1);
    n = 0;
    while (!o_warn && n < 100) begin
      cyc();
      n++;
    end
    chk("fr_warn_rise", n, 40);
    wait_change(100, n);
    chk("fr_end", n, 20);
    chk("fr_ret_mode", o_mode, 1);
    chk("fr_ret_chg", o_chg, 0);
    wait_change(400, n);
    chk("fr_p1_rest", n, 170);
    chk("fr_p2_mode", o_mode, 2);

    // level 3 fright length
    do_clear_start(3);
    repeat (4) cyc();
    pellet = 1; cyc(); pellet = 0;
    chk("l3_mode", o_mode, 3);
    wait_change(100, n);
    chk("l3_len", n, 30);
    chk("l3_ret", o_mode, 2);

    // pellet re-eaten mid fright
    do_clear_start(1);
    repeat (4) cyc();
    pellet = 1; cyc(); pellet = 0;
    bad = 0;
    repeat (49) begin
      cyc();
      if (o_chg) bad++;
    end
    chk("re_warn_before", o_warn, 1);
    pellet = 1; cyc(); pellet = 0;
    chk("re_mode", o_mode, 3);
    if (o_chg) bad++;
    chk("re_warn_after", o_warn, 0);
    wait_change(200, n);
    chk("re_len", n, 60);
    chk("re_nochg", bad, 0);
    chk("re_ret", o_mode, 2);

    // pause in scatter
    do_clear_start(1);
    repeat (14) cyc();
    pause = 1; cyc(); pause = 0;
    chk("pz_mode", o_mode, 5);
    bad = 0; tk = 0;
    repeat (500) begin
      cyc();
      if (o_mode != 5) bad++;
      if (o_tick) tk++;
    end
    chk("pz_hold", bad, 0);
    chk("pz_ticks", tk, 0);
    pause = 1; cyc(); pause = 0;
    chk("pz_resume", o_mode, 2);
    wait_change(200, n);
    chk("pz_remain", n, 60);

    // step periods in chase
    chk("sp_chase", o_mode, 1);
    speed = 4;
    repeat (10) cyc();
    tk = 0; gaps = 0; last = -1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (o_tick) begin
        if (last >= 0 && i - last != 4) gaps++;
        last = i;
        tk++;
      end
    end
    chk("sp4_count", tk, 6);
    chk("sp4_gaps", gaps, 0);
    speed = 0;
    repeat (8) cyc();
    tk = 0;
    repeat (10) begin
      cyc();
      if (o_tick) tk++;
    end
    chk("sp0_count", tk, 10);

    // randomized run against the model
    rst = 1; idle_inputs(); cyc(); rst = 0;
    model_reset();
    level = 1; speed = 2;
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 19) == 0);
      pause  = ($urandom_range(0, 59) == 0);
      pellet = ($urandom_range(0, 39) == 0);
      died   = ($urandom_range(0, 149) == 0);
      clear  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) level = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) speed = 28'($urandom_range(0, 6));
      model_step();
      cyc();
      chk("rnd_mode", o_mode, m_mode);
      chk("rnd_phase", o_phase, m_phase);
      chk("rnd_chg", o_chg, e_chg);
      chk("rnd_warn", o_warn, e_warn);
      chk("rnd_tick", o_tick, e_tick);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
